regfile_alu_pipe: RTL and testbench

//  Parametrised register file plus ALU execute unit with valid/ready issue handshake.

---
 rtl/regfile_alu_pipe.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_regfile_alu_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_alu_pipe.sv
// -----------------------------------------------------------------------------
// regfile_alu_pipe
//
// Register file plus ALU execute unit with a valid/ready issue handshake.
// Each accepted instruction reads Reg[Rdest] and a source operand, which is
// either Reg[Rsrc] or the immediate. It writes the result back to Reg[Rdest]
// and updates Flags. Single-cycle ops commit at the accept edge. The optional
// multiply runs as a shift-add over WIDTH cycles in a small two-state FSM.
//
// Optional feature macro: REGFILE_ALU_MUL_EN
//   defined     -> opcode 09 is an unsigned multiply (low WIDTH bits kept)
//   not defined -> opcode 09 is a NOP and In_Ready is constant 1 out of reset
//
// Ports
//   Clk          in   rising-edge clock
//   Rst          in   asynchronous reset, active low
//   In_Valid     in   instruction present
//   In_Ready     out  unit can accept (transfer on In_Valid & In_Ready)
//   OpCode       in   [4:0] operation select
//   RdestRegLoc  in   destination / first-operand register
//   RsrcRegLoc   in   source register
//   Imm          in   immediate operand
//   Imm_s        in   1: source is Imm, 0: source is Reg[RsrcRegLoc]
//   AluOutput    out  registered result of the last completed op
//   Out_Valid    out  one-cycle pulse when an op completes
//   Flags        out  registered {C,L,F,Z,N} in bits [4:0]
//   RdestOut     out  combinational read of Reg[RdestRegLoc]
// -----------------------------------------------------------------------------
module regfile_alu_pipe #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [4:0]        OpCode,
    input  logic [ADDR_W-1:0] RdestRegLoc,
    input  logic [ADDR_W-1:0] RsrcRegLoc,
    input  logic [WIDTH-1:0]  Imm,
    input  logic              Imm_s,
    output logic [WIDTH-1:0]  AluOutput,
    output logic              Out_Valid,
    output logic [4:0]        Flags,
    output logic [WIDTH-1:0]  RdestOut
);

    localparam int REGS = 2 ** ADDR_W;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_CMP = 5'd5;
    localparam logic [4:0] OP_MOV = 5'd6;
    localparam logic [4:0] OP_LSH = 5'd7;
    localparam logic [4:0] OP_RSH = 5'd8;
`ifdef REGFILE_ALU_MUL_EN
    localparam logic [4:0] OP_MUL = 5'd9;
`endif

    logic [WIDTH-1:0] regs [REGS];

    logic             accept;
    logic [WIDTH-1:0] rdVal;
    logic [WIDTH-1:0] srcVal;
    logic [WIDTH:0]   addFull;
    logic [WIDTH:0]   subFull;
    logic [3:0]       shAmt;
    logic             shOut;

    logic [WIDTH-1:0] aluResult;
    logic [4:0]       aluFlags;
    logic             aluWrite;

    logic             opIsMul;
    logic             mulDone;
    logic [ADDR_W-1:0] mulDest;
    logic [WIDTH-1:0] mulResult;

    logic              commitValid;
    logic              commitWrite;
    logic [ADDR_W-1:0] commitAddr;
    logic [WIDTH-1:0]  commitData;
    logic [4:0]        commitFlags;

    assign accept   = In_Valid & In_Ready;
    assign rdVal    = regs[RdestRegLoc];
    assign srcVal   = Imm_s ? Imm : regs[RsrcRegLoc];
    assign RdestOut = rdVal;

    // The extra top bit of addFull is the carry out. The extra top bit of
    // subFull is the borrow, which is set exactly when rdVal < srcVal unsigned.
    assign addFull = {1'b0, rdVal} + {1'b0, srcVal};
    assign subFull = {1'b0, rdVal} - {1'b0, srcVal};
    assign shAmt   = srcVal[3:0];
    assign shOut   = (int'(shAmt) >= WIDTH);

    // Single-cycle ALU. Flags default to their current value so that a NOP
    // leaves them untouched. Write-producing ops overwrite every flag bit.
    always_comb begin
        aluResult = '0;
        aluFlags  = Flags;
        aluWrite  = 1'b0;
        case (OpCode)
            OP_ADD: begin
                aluResult = addFull[WIDTH-1:0];
                aluWrite  = 1'b1;
                aluFlags  = {addFull[WIDTH], 1'b0,
                             (rdVal[WIDTH-1] == srcVal[WIDTH-1]) &&
                             (addFull[WIDTH-1] != rdVal[WIDTH-1]),
                             (addFull[WIDTH-1:0] == '0), addFull[WIDTH-1]};
            end
            OP_SUB: begin
                aluResult = subFull[WIDTH-1:0];
                aluWrite  = 1'b1;
                aluFlags  = {subFull[WIDTH], 1'b0,
                             (rdVal[WIDTH-1] != srcVal[WIDTH-1]) &&
                             (subFull[WIDTH-1] != rdVal[WIDTH-1]),
                             (subFull[WIDTH-1:0] == '0), subFull[WIDTH-1]};
            end
            OP_AND: begin
                aluResult = rdVal & srcVal;
                aluWrite  = 1'b1;
            end
            OP_OR: begin
                aluResult = rdVal | srcVal;
                aluWrite  = 1'b1;
            end
            OP_XOR: begin
                aluResult = rdVal ^ srcVal;
                aluWrite  = 1'b1;
            end
            OP_CMP: begin
                // Compare reports the difference on AluOutput but never writes back.
                aluResult = subFull[WIDTH-1:0];
                aluFlags  = {1'b0, subFull[WIDTH], 1'b0, (rdVal == srcVal),
                             ($signed(rdVal) < $signed(srcVal))};
            end
            OP_MOV: begin
                aluResult = srcVal;
                aluWrite  = 1'b1;
            end
            OP_LSH: begin
                aluResult = shOut ? '0 : (rdVal << shAmt);
                aluWrite  = 1'b1;
            end
            OP_RSH: begin
                aluResult = shOut ? '0 : (rdVal >> shAmt);
                aluWrite  = 1'b1;
            end
            default: begin
                aluResult = '0;
            end
        endcase
        if (aluWrite) begin
            aluFlags[3] = 1'b0;
            aluFlags[1] = (aluResult == '0);
            aluFlags[0] = aluResult[WIDTH-1];
            if ((OpCode != OP_ADD) && (OpCode != OP_SUB)) begin
                aluFlags[4] = 1'b0;
                aluFlags[2] = 1'b0;
            end
        end
    end

`ifdef REGFILE_ALU_MUL_EN
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [CNT_W-1:0]  mulCount;
    logic [WIDTH-1:0]  mulA;
    logic [WIDTH-1:0]  mulB;
    logic [WIDTH-1:0]  mulAcc;
    logic [ADDR_W-1:0] mulDestReg;
    logic [WIDTH-1:0]  accStep;

    assign opIsMul   = (OpCode == OP_MUL);
    assign In_Ready  = (state == S_IDLE);
    assign accStep   = mulAcc + (mulB[0] ? mulA : '0);
    assign mulDone   = (state == S_MUL) && (mulCount == LAST_CNT);
    assign mulResult = accStep;
    assign mulDest   = mulDestReg;

    // Multiply FSM state register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: stay in S_MUL for exactly WIDTH shift-add steps.
    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE: if (accept && opIsMul) stateNext = S_MUL;
            S_MUL:  if (mulCount == LAST_CNT) stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // Shift-add datapath. Operands are latched at accept. Each step adds the
    // shifted multiplicand when the current multiplier LSB is set. Bits
    // shifted past WIDTH are dropped, which keeps only the low half of the product.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mulCount   <= '0;
            mulA       <= '0;
            mulB       <= '0;
            mulAcc     <= '0;
            mulDestReg <= '0;
        end else if ((state == S_IDLE) && accept && opIsMul) begin
            mulCount   <= '0;
            mulA       <= rdVal;
            mulB       <= srcVal;
            mulAcc     <= '0;
            mulDestReg <= RdestRegLoc;
        end else if (state == S_MUL) begin
            mulCount <= mulCount + 1'b1;
            mulA     <= mulA << 1;
            mulB     <= mulB >> 1;
            mulAcc   <= accStep;
        end
    end
`else
    assign opIsMul   = 1'b0;
    assign In_Ready  = 1'b1;
    assign mulDone   = 1'b0;
    assign mulDest   = '0;
    assign mulResult = '0;
`endif

    // Select what retires this cycle. A finishing multiply and a fresh accept
    // can never coincide, because In_Ready is low throughout the multiply.
    always_comb begin
        commitValid = 1'b0;
        commitWrite = 1'b0;
        commitAddr  = RdestRegLoc;
        commitData  = '0;
        commitFlags = Flags;
        if (mulDone) begin
            commitValid = 1'b1;
            commitWrite = 1'b1;
            commitAddr  = mulDest;
            commitData  = mulResult;
            commitFlags = {3'b000, (mulResult == '0), mulResult[WIDTH-1]};
        end else if (accept && !opIsMul) begin
            commitValid = 1'b1;
            commitWrite = aluWrite;
            commitData  = aluResult;
            commitFlags = aluFlags;
        end
    end

    // Register file write-back and the registered result/flag outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < REGS; i++) begin
                regs[i] <= '0;
            end
            AluOutput <= '0;
            Flags     <= '0;
            Out_Valid <= 1'b0;
        end else begin
            Out_Valid <= commitValid;
            if (commitValid) begin
                AluOutput <= commitData;
                Flags     <= commitFlags;
                if (commitWrite) begin
                    regs[commitAddr] <= commitData;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_regfile_alu_pipe
//
// Self-checking bench for regfile_alu_pipe (WIDTH=16, ADDR_W=4). It runs a
// directed sequence followed by random instructions. Each result is compared
// against an arithmetic reference model held in the bench.
// The multiply checks are built only when REGFILE_ALU_MUL_EN is defined.
// -----------------------------------------------------------------------------
module tb_regfile_alu_pipe;

    localparam int W    = 16;
    localparam int MOD  = 1 << W;
    localparam int HALF = 1 << (W - 1);
`ifdef REGFILE_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        In_Valid = 1'b0;
    logic        In_Ready;
    logic [4:0]  OpCode = '0;
    logic [3:0]  RdestRegLoc = '0;
    logic [3:0]  RsrcRegLoc = '0;
    logic [15:0] Imm = '0;
    logic        Imm_s = 1'b0;
    logic [15:0] AluOutput;
    logic        Out_Valid;
    logic [4:0]  Flags;
    logic [15:0] RdestOut;

    int checks = 0;
    int errors = 0;

    int         mregs [16];
    logic [4:0] mflags;

    regfile_alu_pipe #(.WIDTH(16), .ADDR_W(4)) dut (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .OpCode(OpCode), .RdestRegLoc(RdestRegLoc), .RsrcRegLoc(RsrcRegLoc),
        .Imm(Imm), .Imm_s(Imm_s), .AluOutput(AluOutput), .Out_Valid(Out_Valid),
        .Flags(Flags), .RdestOut(RdestOut)
    );

    always #5 Clk = ~Clk;

    // Watchdog so that a stuck design can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int toSigned(input int v);
        return (v >= HALF) ? v - MOD : v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural state.
    task automatic modelOp(input int op, input int rd, input int rs, input int imm, input bit imms,
                           output int expOut, output bit chkOut, output bit isMul);
        int a, b, r, s, amt;
        bit c, f, wr;
        a = mregs[rd];
        b = imms ? imm : mregs[rs];
        amt = b % 16;
        r = 0; c = 0; f = 0; wr = 1; chkOut = 1; isMul = 0;
        case (op)
            0: begin
                r = a + b; c = (r >= MOD); r = r % MOD;
                s = toSigned(a) + toSigned(b); f = (s >= HALF) || (s < -HALF);
            end
            1: begin
                r = a - b; c = (a < b); if (r < 0) r = r + MOD;
                s = toSigned(a) - toSigned(b); f = (s >= HALF) || (s < -HALF);
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin
                wr = 0; chkOut = 0;
                mflags = {1'b0, (a < b), 1'b0, (a == b), (toSigned(a) < toSigned(b))};
            end
            6: r = b;
            7: r = (amt >= W) ? 0 : int'((longint'(a) << amt) % MOD);
            8: r = (amt >= W) ? 0 : (a >> amt);
            9: begin
                if (MUL_EN) begin
                    isMul = 1;
                    r = int'((longint'(a) * longint'(b)) % MOD);
                end else begin
                    wr = 0;
                end
            end
            default: wr = 0;
        endcase
        expOut = r;
        if (wr) begin
            mregs[rd] = r;
            mflags = {c, 1'b0, f, (r == 0), (r >= HALF)};
        end
    endtask

    // Present one instruction, wait for it to be accepted, then check its result.
    task automatic applyStimulus(input string tag, input int op, input int rd, input int rs,
                                 input int imm, input bit imms);
        int expOut, waitCnt, lat, lowCyc;
        bit chkOut, isMul;
        OpCode      = op[4:0];
        RdestRegLoc = rd[3:0];
        RsrcRegLoc  = rs[3:0];
        Imm         = imm[15:0];
        Imm_s       = imms;
        In_Valid    = 1'b1;
        waitCnt = 0;
        while (!In_Ready && waitCnt < 100) begin
            @(posedge Clk); #1;
            waitCnt++;
        end
        checkOutput({tag, "_ready"}, {31'b0, In_Ready}, 32'd1);
        modelOp(op, rd, rs, imm, imms, expOut, chkOut, isMul);
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        lat = 1;
        lowCyc = 0;
        if (isMul) begin
            while (!Out_Valid && lat < 100) begin
                if (!In_Ready) lowCyc++;
                @(posedge Clk); #1;
                lat++;
            end
            checkOutput({tag, "_latency"}, lat, W + 1);
            checkOutput({tag, "_busy"}, lowCyc, W);
            checkOutput({tag, "_readyAtDone"}, {31'b0, In_Ready}, 32'd1);
        end
        checkOutput({tag, "_outValid"}, {31'b0, Out_Valid}, 32'd1);
        if (chkOut) checkOutput({tag, "_aluOut"}, {16'b0, AluOutput}, expOut);
        checkOutput({tag, "_flags"}, {27'b0, Flags}, {27'b0, mflags});
        checkOutput({tag, "_rdest"}, {16'b0, RdestOut}, mregs[rd]);
    endtask

    task automatic idleCycle(input string tag);
        In_Valid = 1'b0;
        @(posedge Clk); #1;
        checkOutput({tag, "_idleOutValid"}, {31'b0, Out_Valid}, 32'd0);
    endtask

    // While reset is held, every register must read 0 and the outputs must be idle.
    task automatic checkReset(input string tag);
        for (int i = 0; i < 16; i++) begin
            RdestRegLoc = i[3:0];
            #1;
            checkOutput($sformatf("%s_reg%0d", tag, i), {16'b0, RdestOut}, 32'd0);
        end
        checkOutput({tag, "_outValid"}, {31'b0, Out_Valid}, 32'd0);
        checkOutput({tag, "_flags"}, {27'b0, Flags}, 32'd0);
        checkOutput({tag, "_ready"}, {31'b0, In_Ready}, 32'd1);
        for (int i = 0; i < 16; i++) mregs[i] = 0;
        mflags = '0;
    endtask

    task automatic pulseReset(input string tag);
        In_Valid = 1'b0;
        Rst = 1'b0;
        #2;
        checkReset(tag);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk); #1;
    endtask

    initial begin
        int op, rd, rs, imm;
        bit imms;
        for (int i = 0; i < 16; i++) mregs[i] = 0;
        mflags = '0;

        $display("[TB] reset checks");
        #12;
        checkReset("rst0");
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk); #1;

        $display("[TB] directed sequence");
        applyStimulus("movR1", 6, 1, 0, 0, 1'b1);
        applyStimulus("addR1a", 0, 1, 0, 5, 1'b1);
        applyStimulus("addR1b", 0, 1, 0, 7, 1'b1);
        checkOutput("r1is12", {16'b0, RdestOut}, 32'd12);
        idleCycle("afterAdd");

        applyStimulus("movR2", 6, 2, 0, 16'h7FFF, 1'b1);
        applyStimulus("ovfAdd", 0, 2, 0, 1, 1'b1);
        checkOutput("ovfAddFlags", {27'b0, Flags}, 32'b00101);
        applyStimulus("carryAdd", 0, 2, 0, 16'h8000, 1'b1);
        checkOutput("carryAddFlags", {27'b0, Flags}, 32'b10110);

        applyStimulus("movR3", 6, 3, 0, 3, 1'b1);
        applyStimulus("movR4", 6, 4, 0, 16'hFFFF, 1'b1);
        applyStimulus("cmpR3R4", 5, 3, 4, 0, 1'b0);
        checkOutput("cmpR3R4Flags", {27'b0, Flags}, 32'b01000);
        applyStimulus("cmpR3R3", 5, 3, 3, 0, 1'b0);
        checkOutput("cmpR3R3Flags", {27'b0, Flags}, 32'b00010);
        checkOutput("r3kept", {16'b0, RdestOut}, 32'd3);

        applyStimulus("subBorrow", 1, 3, 4, 0, 1'b0);
        applyStimulus("movR6", 6, 6, 0, 3, 1'b1);
        applyStimulus("lsh15", 7, 6, 0, 15, 1'b1);
        applyStimulus("rshUpper", 8, 6, 0, 16'h00F0, 1'b1);
        applyStimulus("rsh15", 8, 6, 0, 15, 1'b1);
        applyStimulus("nop1F", 31, 6, 0, 16'h1234, 1'b1);

        applyStimulus("movR5", 6, 5, 0, 300, 1'b1);
        applyStimulus("op09", 9, 5, 0, 200, 1'b1);
`ifdef REGFILE_ALU_MUL_EN
        checkOutput("mulValue", {16'b0, RdestOut}, 32'hEA60);
        checkOutput("mulFlags", {27'b0, Flags}, 32'b00001);
`else
        checkOutput("nop09Keep", {16'b0, RdestOut}, 32'd300);
        checkOutput("nop09Out", {16'b0, AluOutput}, 32'd0);
`endif
        idleCycle("afterOp09");

        $display("[TB] random sequence");
        for (int n = 0; n < 300; n++) begin
            op   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 31)) : int'($urandom_range(0, 9));
            rd   = $urandom_range(0, 15);
            rs   = $urandom_range(0, 15);
            case ($urandom_range(0, 5))
                0: imm = 0;
                1: imm = 16'hFFFF;
                2: imm = 16'h8000;
                default: imm = $urandom_range(0, 16'hFFFF);
            endcase
            imms = 1'($urandom_range(0, 1));
            applyStimulus($sformatf("rand%0d", n), op, rd, rs, imm, imms);
            if ($urandom_range(0, 4) == 0) idleCycle($sformatf("randIdle%0d", n));
        end

        $display("[TB] reset mid-run");
        pulseReset("rstMid");
        applyStimulus("postRst", 0, 7, 7, 9, 1'b0);

`ifdef REGFILE_ALU_MUL_EN
        $display("[TB] reset during multiply");
        applyStimulus("movR5b", 6, 5, 0, 300, 1'b1);
        OpCode = 5'd9; RdestRegLoc = 4'd5; Imm = 16'd200; Imm_s = 1'b1;
        In_Valid = 1'b1;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        repeat (5) begin
            @(posedge Clk); #1;
        end
        checkOutput("mulBusy", {31'b0, In_Ready}, 32'd0);
        pulseReset("rstMul");
        RdestRegLoc = 4'd5;
        repeat (W + 2) begin
            @(posedge Clk); #1;
            checkOutput("noLateMul", {31'b0, Out_Valid}, 32'd0);
        end
        checkOutput("r5Cleared", {16'b0, RdestOut}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
